fifo_wr_rptr_sync: RTL and testbench
====================================

FIFO_WR_RPTR_SYNC -- requirements
Module: fifo_wr_rptr_sync

Interface
REQ-001 SHALL have parameter P_SIZE, default 4, pointer width including wrap bit (depth DEPTH = 2^(P_SIZE-1)).
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (min 2), length of the flop synchronizer chain for the read pointer.
REQ-003 SHALL have parameter AF_THRESH, default 6, almost-full fill threshold (1..DEPTH).
REQ-004 SHALL have port w_clk  input  1  write-domain clock.
REQ-005 SHALL have port w_rstn  input  1  write-domain reset, asynchronous, active-low.
REQ-006 SHALL have port gray_rd_ptr  input  P_SIZE  gray read pointer, registered in the read domain, asynchronous to w_clk.
REQ-007 SHALL have port gray_w_ptr  input  P_SIZE  registered gray write pointer from the write-side pointer logic.
REQ-008 SHALL have port w_inc  input  1  write request seen by the FIFO.
REQ-009 SHALL have port full  input  1  full flag from the write-side pointer logic.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of error status.
REQ-011 SHALL have port sync_rd_ptr  output  P_SIZE  synchronized gray read pointer (last sync stage).
REQ-012 SHALL have port bin_rd_ptr  output  P_SIZE  registered binary read pointer.
REQ-013 SHALL have port fill_level  output  P_SIZE  registered write-domain occupancy, range 0..DEPTH.
REQ-014 SHALL have port almost_full  output  1  fill_level >= AF_THRESH.
REQ-015 SHALL have port ovf_err  output  1  sticky: write attempted while full.
REQ-016 SHALL have port ovf_cnt  output  8  saturating count of rejected writes.
REQ-017 SHALL have port ptr_err  output  1  sticky: illegal gray transition or impossible occupancy.

Function
REQ-018 SHALL sample gray_rd_ptr through SYNC_STAGES flops; a change on gray_rd_ptr captured at edge k SHALL appear on sync_rd_ptr at edge k+SYNC_STAGES-1.
REQ-019 SHALL convert sync_rd_ptr gray-to-binary (b[MSB]=g[MSB], b[i]=b[i+1]^g[i]) and register it into bin_rd_ptr one edge later.
REQ-020 SHALL convert gray_w_ptr to binary combinationally and register fill_level = (bin_w - bin_rd_ptr) mod 2^P_SIZE one edge after bin_rd_ptr updates.
REQ-021 SHALL handle wrap-around purely via modulo-2^P_SIZE subtraction; no special-casing of the wrap bit.
REQ-022 SHALL drive almost_full combinationally from registered fill_level.
REQ-023 SHALL set ovf_err and increment ovf_cnt (saturate at 255) at the edge following any cycle with w_inc=1 and full=1.
REQ-024 SHALL register the previous sync_rd_ptr and set ptr_err when consecutive samples differ in more than one bit, or when computed occupancy exceeds DEPTH.
REQ-025 SHALL clear ovf_err, ovf_cnt, ptr_err on clr_err=1; an error event in the same cycle SHALL win (flag set, ovf_cnt = 1).
REQ-026 SHALL NOT alter gray_w_ptr, full or any write-side state; block is status-only.

Reset
REQ-027 SHALL asynchronously clear all sync stages, sync_rd_ptr, previous-sample register, bin_rd_ptr, fill_level, ovf_err, ovf_cnt, ptr_err to 0 on w_rstn=0; almost_full therefore 0.
REQ-028 SHALL, on reset asserted mid-operation, restart synchronization from zero without flagging ptr_err on the first post-reset sample.

Structure
REQ-029 SHALL place gray-to-binary and binary-to-gray functions plus the DEPTH derivation in the shared FIFO package.
REQ-030 SHALL instantiate one sub-module, fifo_ptr_sync (parameterized multi-stage synchronizer, reusable for the read-side write-pointer sync).

Verification (P_SIZE=4, SYNC_STAGES=2, AF_THRESH=6)
REQ-031 SHALL check latency: gray_rd_ptr 0000->0001 at edge k -> sync_rd_ptr=0001 at k+1, bin_rd_ptr=1 at k+2, fill_level updated at k+3.
REQ-032 SHALL check wrap: bin_w=2 (gray 0011), bin_rd=14 (gray 1001) -> fill_level=4, almost_full=0; bin_w=4 (gray 0110), bin_rd=14 -> fill_level=6, almost_full=1.
REQ-033 SHALL check full: gray_w_ptr=1100 (bin 8), rd=0 -> fill_level=8, almost_full=1, ptr_err=0.
REQ-034 SHALL check overflow: full=1, w_inc=1 for 3 cycles -> ovf_cnt=3, ovf_err=1; clr_err with a 4th overflow in same cycle -> ovf_cnt=1, ovf_err=1.
REQ-035 SHALL check pointer error: gray_rd_ptr 0000->0011 -> ptr_err=1 at the edge after sync_rd_ptr shows 0011; clr_err -> 0.
REQ-036 SHALL check reset mid-operation: w_rstn low with fill_level=5, ovf_cnt=2 -> all outputs 0 immediately; no ptr_err after release.

Source files
------------

// File: rtl/fifo_wr_rptr_sync_pkg.sv
// Shared FIFO helpers: depth derivation and gray/binary pointer conversion.
// Functions work on a wide zero-extended vector, so callers cast to and from their pointer width.
package fifo_wr_rptr_sync_pkg;

    localparam int unsigned PtrMaxW = 16;

    typedef logic [PtrMaxW-1:0] ptr_t;

    // One wrap bit on top of the address bits.
    function automatic int unsigned fifo_depth(input int unsigned p_size);
        return 32'd1 << (p_size - 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PtrMaxW-1] = g[PtrMaxW-1];
        for (int i = PtrMaxW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // True when more than one bit differs between two samples.
    function automatic logic multi_bit_change(input ptr_t a, input ptr_t b);
        ptr_t d;
        d = a ^ b;
        return (d & (d - ptr_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-stage flop synchronizer for a gray-coded pointer crossing clock domains.
module fifo_ptr_sync #(
    parameter int unsigned Width  = 4,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/fifo_wr_rptr_sync.sv
// Write-domain read-pointer synchronizer with occupancy, almost-full and error status.
// Status-only: observes write-side pointer state but never drives it.
module fifo_wr_rptr_sync
    import fifo_wr_rptr_sync_pkg::*;
#(
    parameter int unsigned P_SIZE      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 6
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic [P_SIZE-1:0] gray_rd_ptr,
    input  logic [P_SIZE-1:0] gray_w_ptr,
    input  logic              w_inc,
    input  logic              full,
    input  logic              clr_err,
    output logic [P_SIZE-1:0] sync_rd_ptr,
    output logic [P_SIZE-1:0] bin_rd_ptr,
    output logic [P_SIZE-1:0] fill_level,
    output logic              almost_full,
    output logic              ovf_err,
    output logic [7:0]        ovf_cnt,
    output logic              ptr_err
);

    localparam int unsigned       Depth     = fifo_depth(P_SIZE);
    localparam logic [P_SIZE-1:0] DepthP    = P_SIZE'(Depth);
    localparam logic [P_SIZE-1:0] AfThreshP = P_SIZE'(AF_THRESH);

    logic [P_SIZE-1:0] prev_q;
    logic [P_SIZE-1:0] bin_rd_q, bin_rd_d;
    logic [P_SIZE-1:0] fill_q, fill_d;
    logic [P_SIZE-1:0] bin_w;
    logic              ovf_err_q, ovf_err_d;
    logic [7:0]        ovf_cnt_q, ovf_cnt_d;
    logic              ptr_err_q, ptr_err_d;
    logic [SYNC_STAGES:0] vld_q;
    logic              chk_en;
    logic              ovf_evt, ptr_evt;

    fifo_ptr_sync #(
        .Width  (P_SIZE),
        .Stages (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (w_clk),
        .rst_ni (w_rstn),
        .d_i    (gray_rd_ptr),
        .q_o    (sync_rd_ptr)
    );

    // Checks stay off until the chain, previous sample and binary pointer all hold
    // post-reset data, so the first real sample is never compared against reset zeros.
    assign chk_en = vld_q[SYNC_STAGES];

    always_comb begin
        bin_w    = P_SIZE'(gray2bin(ptr_t'(gray_w_ptr)));
        bin_rd_d = P_SIZE'(gray2bin(ptr_t'(sync_rd_ptr)));
        fill_d   = bin_w - bin_rd_q;
        ovf_evt  = w_inc & full;
        ptr_evt  = chk_en & (multi_bit_change(ptr_t'(prev_q), ptr_t'(sync_rd_ptr)) |
                             (fill_d > DepthP));

        ovf_err_d = ovf_err_q;
        ovf_cnt_d = ovf_cnt_q;
        ptr_err_d = ptr_err_q;

        if (clr_err) begin
            ovf_err_d = ovf_evt;
            ovf_cnt_d = ovf_evt ? 8'd1 : 8'd0;
            ptr_err_d = ptr_evt;
        end else begin
            if (ovf_evt) begin
                ovf_err_d = 1'b1;
                if (ovf_cnt_q != 8'hff) begin
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
                end
            end
            if (ptr_evt) begin
                ptr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            prev_q    <= '0;
            bin_rd_q  <= '0;
            fill_q    <= '0;
            ovf_err_q <= 1'b0;
            ovf_cnt_q <= '0;
            ptr_err_q <= 1'b0;
            vld_q     <= '0;
        end else begin
            prev_q    <= sync_rd_ptr;
            bin_rd_q  <= bin_rd_d;
            fill_q    <= fill_d;
            ovf_err_q <= ovf_err_d;
            ovf_cnt_q <= ovf_cnt_d;
            ptr_err_q <= ptr_err_d;
            vld_q     <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign bin_rd_ptr  = bin_rd_q;
    assign fill_level  = fill_q;
    assign almost_full = fill_q >= AfThreshP;
    assign ovf_err     = ovf_err_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign ptr_err     = ptr_err_q;

endmodule

// File: tb/tb_fifo_wr_rptr_sync.sv
// Scoreboard bench: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_fifo_wr_rptr_sync;

    localparam int S     = 2;
    localparam int AF    = 6;
    localparam int DEPTH = 8;

    logic       w_clk = 1'b0;
    logic       w_rstn = 1'b1;
    logic [3:0] gray_rd_ptr = '0;
    logic [3:0] gray_w_ptr = '0;
    logic       w_inc = 1'b0;
    logic       full = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] sync_rd_ptr, bin_rd_ptr, fill_level;
    logic       almost_full, ovf_err, ptr_err;
    logic [7:0] ovf_cnt;

    fifo_wr_rptr_sync #(
        .P_SIZE      (4),
        .SYNC_STAGES (S),
        .AF_THRESH   (AF)
    ) dut (
        .w_clk       (w_clk),
        .w_rstn      (w_rstn),
        .gray_rd_ptr (gray_rd_ptr),
        .gray_w_ptr  (gray_w_ptr),
        .w_inc       (w_inc),
        .full        (full),
        .clr_err     (clr_err),
        .sync_rd_ptr (sync_rd_ptr),
        .bin_rd_ptr  (bin_rd_ptr),
        .fill_level  (fill_level),
        .almost_full (almost_full),
        .ovf_err     (ovf_err),
        .ovf_cnt     (ovf_cnt),
        .ptr_err     (ptr_err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        int sync; int bin; int fill; int af; int oe; int oc; int pe;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n = 0;
    int   rd_hist[$];
    int   w_hist[$];
    int   m_oe = 0, m_oc = 0, m_pe = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference conversions by search and plain arithmetic.
    function automatic int g2b(input int g);
        for (int b = 0; b < 16; b++) if (((b ^ (b >> 1)) & 15) == g) return b;
        return 0;
    endfunction

    function automatic int b2g(input int b);
        int v;
        v = b & 15;
        return v ^ (v >> 1);
    endfunction

    function automatic int ones(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // Input value sampled at edge m since reset release; zero before the first edge.
    function automatic int rd_at(input int m);
        return (m < 1) ? 0 : rd_hist[m-1];
    endfunction

    function automatic int w_at(input int m);
        return (m < 1) ? 0 : w_hist[m-1];
    endfunction

    task automatic model_reset();
        n = 0;
        rd_hist.delete();
        w_hist.delete();
        exp_q.delete();
        m_oe = 0;
        m_oc = 0;
        m_pe = 0;
    endtask

    task automatic model_edge();
        exp_t e;
        int   fill;
        bit   pe_evt, oe_evt;
        n++;
        rd_hist.push_back(int'(gray_rd_ptr));
        w_hist.push_back(int'(gray_w_ptr));
        fill   = (g2b(w_at(n)) - g2b(rd_at(n - S - 1)) + 16) % 16;
        pe_evt = (n >= S + 2) &&
                 ((ones(rd_at(n - S) ^ rd_at(n - S - 1)) > 1) || (fill > DEPTH));
        oe_evt = w_inc && full;
        if (clr_err) begin
            m_oe = oe_evt;
            m_oc = oe_evt ? 1 : 0;
            m_pe = pe_evt;
        end else begin
            if (oe_evt) begin
                m_oe = 1;
                if (m_oc < 255) m_oc++;
            end
            if (pe_evt) m_pe = 1;
        end
        e.sync = rd_at(n - S + 1);
        e.bin  = g2b(rd_at(n - S));
        e.fill = fill;
        e.af   = (fill >= AF) ? 1 : 0;
        e.oe   = m_oe;
        e.oc   = m_oc;
        e.pe   = m_pe;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input int gw, input int grd, input bit inc, input bit fl, input bit clr);
        gray_w_ptr  = 4'(gw);
        gray_rd_ptr = 4'(grd);
        w_inc       = inc;
        full        = fl;
        clr_err     = clr;
        @(posedge w_clk);
        if (w_rstn) model_edge();
        @(negedge w_clk);
    endtask

    task automatic step_b(input int wb, input int rb, input int k);
        repeat (k) cycle(b2g(wb), b2g(rb), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero();
        check("rst_sync_rd_ptr", int'(sync_rd_ptr), 0);
        check("rst_bin_rd_ptr", int'(bin_rd_ptr), 0);
        check("rst_fill_level", int'(fill_level), 0);
        check("rst_almost_full", int'(almost_full), 0);
        check("rst_ovf_err", int'(ovf_err), 0);
        check("rst_ovf_cnt", int'(ovf_cnt), 0);
        check("rst_ptr_err", int'(ptr_err), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge w_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sync_rd_ptr", int'(sync_rd_ptr), e.sync);
                check("bin_rd_ptr", int'(bin_rd_ptr), e.bin);
                check("fill_level", int'(fill_level), e.fill);
                check("almost_full", int'(almost_full), e.af);
                check("ovf_err", int'(ovf_err), e.oe);
                check("ovf_cnt", int'(ovf_cnt), e.oc);
                check("ptr_err", int'(ptr_err), e.pe);
            end
        end
    end

    initial begin : stim
        int wb, rb;
        #1 w_rstn = 1'b0;
        #1 chk_zero();
        model_reset();
        @(negedge w_clk);
        @(negedge w_clk);
        w_rstn = 1'b1;

        // Latency of a single read-pointer step, then a legal walk up to rd=14.
        step_b(0, 0, 3);
        step_b(1, 0, 3);
        step_b(1, 1, 4);
        for (int b = 2; b <= 14; b++) step_b(b, b, 1);
        step_b(14, 14, 4);

        // Write pointer wraps past the read pointer.
        step_b(15, 14, 1);
        step_b(0, 14, 1);
        step_b(1, 14, 1);
        step_b(2, 14, 4);
        step_b(4, 14, 4);

        // Read wraps to 0, then exactly DEPTH entries.
        step_b(4, 15, 1);
        step_b(4, 0, 4);
        step_b(8, 0, 4);

        // Overflow counting, clear racing a fresh overflow, one more overflow.
        repeat (3) cycle(b2g(8), 0, 1'b1, 1'b1, 1'b0);
        cycle(b2g(8), 0, 1'b1, 1'b1, 1'b1);
        cycle(b2g(8), 0, 1'b1, 1'b1, 1'b0);
        step_b(8, 1, 1);
        step_b(8, 2, 1);
        step_b(8, 3, 4);

        // Asynchronous reset mid-operation with a non-zero read pointer held across release.
        #2 w_rstn = 1'b0;
        #1 chk_zero();
        model_reset();
        gray_rd_ptr = 4'(b2g(2));
        gray_w_ptr  = 4'(b2g(2));
        @(negedge w_clk);
        @(negedge w_clk);
        w_rstn = 1'b1;
        step_b(2, 2, 6);

        // Two-bit gray jump on the read pointer, then clear.
        step_b(6, 2, 4);
        step_b(6, 6, 4);
        cycle(b2g(6), b2g(6), 1'b0, 1'b0, 1'b1);
        step_b(6, 6, 2);

        // Counter saturation, then a plain clear.
        repeat (260) cycle(b2g(6), b2g(6), 1'b1, 1'b1, 1'b0);
        cycle(b2g(6), b2g(6), 1'b0, 1'b0, 1'b1);
        step_b(6, 6, 2);

        wb = 6;
        rb = 6;
        repeat (2000) begin
            if ($urandom_range(0, 3) == 0 && rb != wb) rb = (rb + 1) % 16;
            if ($urandom_range(0, 31) == 0) rb = (rb + 2) % 16;
            if ($urandom_range(0, 2) == 0 && ((wb - rb + 16) % 16) < 7) wb = (wb + 1) % 16;
            cycle(b2g(wb), b2g(rb), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end

        repeat (2) @(negedge w_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
